// File: rtl/program_counter_pkg.sv
// Shared rv32i constants so fetch, ALU and PC agree on datapath width and boot address.
package program_counter_pkg;
  localparam int unsigned          XLEN         = 32;
  localparam logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/program_counter.sv
// RV32I program counter: one register loaded every rising edge with the upstream-selected next PC.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned     P_XLEN         = XLEN,
  parameter logic [P_XLEN-1:0] P_RESET_VECTOR = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [P_XLEN-1:0] next_pc,
  output logic [P_XLEN-1:0] pc
);

  logic [P_XLEN-1:0] r_pc;

  // Loaded verbatim: alignment and wrap are the datapath's concern.
  always_ff @(posedge clk) begin
    if (rst) r_pc <= P_RESET_VECTOR;
    else     r_pc <= next_pc;
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Table-driven bench with an expected-value scoreboard for program_counter.
module tb_program_counter;
  import program_counter_pkg::*;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] exp_q[$];

  program_counter dut (
    .clk     (clk),
    .rst     (rst),
    .next_pc (next_pc),
    .pc      (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, queue the expected pc, then pop it after the edge.
  task automatic step(input string name, input logic r, input logic [XLEN-1:0] npc,
                      input logic [XLEN-1:0] exp);
    logic [XLEN-1:0] e;
    rst     = r;
    next_pc = npc;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, pc);
    end else begin
      e = exp_q.pop_front();
      check(name, pc, e);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, pc=%h", pc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0000_0004};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0000_0008};
    vecs[4]  = '{1'b1, 32'h0000_0008, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_0008, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h0000_000C, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[8]  = '{1'b0, 32'h0000_1002, 32'h0000_1002};
    vecs[9]  = '{1'b0, 32'h0000_0003, 32'h0000_0003};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'hA5A5_A5A4, 32'hA5A5_A5A4};

    rst     = 1'b1;
    next_pc = '0;

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].npc, vecs[i].exp);

    // next_pc moving mid-cycle must not reach pc before the edge.
    step("load_10", 1'b0, 32'h0000_0010, 32'h0000_0010);
    next_pc = 32'h0000_0020;
    #2;
    check("no_comb_path", pc, 32'h0000_0010);
    step("load_20", 1'b0, 32'h0000_0020, 32'h0000_0020);

    // rst raised between edges takes effect only at the next edge.
    rst = 1'b1;
    #2;
    check("sync_rst_hold", pc, 32'h0000_0020);
    step("sync_rst_edge", 1'b1, 32'h0000_0040, 32'h0000_0000);

    // First edge after release loads next_pc.
    step("rst_release", 1'b0, 32'h0000_0044, 32'h0000_0044);
    step("rand_a", 1'b0, 32'h1234_5678, 32'h1234_5678);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
